// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: pointer widths, the output
// buffer depth and the Gray/binary conversion helpers used by both the read-
// and write-side controllers.
package fifo_pkg;

  // Default memory address width; pointers carry one extra wrap bit.
  localparam int ADDRSIZE_DFLT = 3;
  localparam int PTRW          = ADDRSIZE_DFLT + 1;

  // Output skid buffer depth on the read side.
  localparam int BUF_DEPTH = 2;

  // Conversion helpers work on a wide word so any pointer width up to GRAYW
  // can use them; callers zero-extend on the way in and truncate on the way out.
  localparam int GRAYW = 16;
  typedef logic [GRAYW-1:0] gray_word_t;

  function automatic gray_word_t bin2gray(input gray_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t gray);
    gray_word_t bin;
    bin[GRAYW-1] = gray[GRAYW-1];
    for (int i = GRAYW - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry skid buffer on the read side. A word arriving from memory (push)
// is visible on o_data in the same cycle when the buffer is empty, so a word
// can reach the consumer one cycle after the memory read is issued. A word
// that is not taken that cycle is stored, so o_data stays steady under
// backpressure.
module fifo_out_buf
  import fifo_pkg::*;
#(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [DATAW-1:0] i_push_data,
  input  logic             i_pop,
  output logic [DATAW-1:0] o_data,
  output logic [1:0]       o_count,
  output logic             o_valid
);

  localparam logic [1:0] FULL_CNT = 2'(BUF_DEPTH);

  logic [DATAW-1:0] r_head;
  logic [DATAW-1:0] r_tail;
  logic [1:0]       r_count;
  logic             w_stored;

  assign w_stored = (r_count != 2'd0);
  assign o_count  = r_count;
  assign o_valid  = w_stored | i_push;

  // Head of the queue: a stored word wins, otherwise the word arriving now.
  always_comb begin
    o_data = r_head;
    if (w_stored) begin
      o_data = r_head;
    end else if (i_push) begin
      o_data = i_push_data;
    end else begin
      o_data = r_head;
    end
  end

  // Storage update for push, pop, or both at once with order preserved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= {DATAW{1'b0}};
      r_tail  <= {DATAW{1'b0}};
      r_count <= 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head  <= i_push_data;
            r_count <= 2'd1;
          end else if (r_count == 2'd1) begin
            r_tail  <= i_push_data;
            r_count <= FULL_CNT;
          end else begin
            r_count <= r_count;
          end
        end
        2'b01: begin
          if (r_count != 2'd0) begin
            r_head  <= r_tail;
            r_count <= r_count - 2'd1;
          end else begin
            r_count <= r_count;
          end
        end
        2'b11: begin
          // Empty: the arriving word goes straight to the consumer.
          if (r_count == 2'd1) begin
            r_head <= i_push_data;
          end else if (r_count == 2'd2) begin
            r_head <= r_tail;
            r_tail <= i_push_data;
          end else begin
            r_count <= r_count;
          end
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the asynchronous FIFO (read clock domain only).
// Keeps the binary/Gray read pointer, decides when to issue a memory read,
// tracks the word in flight from memory and reports fill level to the consumer.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE  = 3,
  parameter int DATAW     = 8,
  parameter int AEMPTY_TH = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   sync_wptr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                ren,
  input  logic [DATAW-1:0]    rdata_mem,
  output logic [DATAW-1:0]    rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE+1:0] rlevel
);

  localparam int RPTRW = ADDRSIZE + 1;
  localparam int LVLW  = ADDRSIZE + 2;

  logic [RPTRW-1:0] r_rbin;
  logic [RPTRW-1:0] r_rptr;
  logic             r_inflight;

  logic [RPTRW-1:0] w_wbin;
  logic [RPTRW-1:0] w_rbin_nxt;
  logic [RPTRW-1:0] w_rgray_nxt;
  logic [RPTRW-1:0] w_mem_count;
  logic             w_mem_empty;
  logic             w_pop;
  logic             w_ren;
  logic             w_buf_valid;
  logic [1:0]       w_buf_cnt;
  logic [2:0]       w_occ;
  logic [DATAW-1:0] w_buf_data;
  logic [LVLW-1:0]  w_level;

  // Words in memory: synchronized write pointer minus read pointer, modulo
  // the pointer range, so multi-count jumps of the writer need no care.
  assign w_wbin      = RPTRW'(gray2bin({{(GRAYW-RPTRW){1'b0}}, sync_wptr}));
  assign w_mem_count = w_wbin - r_rbin;
  assign w_mem_empty = (r_rptr == sync_wptr);

  // Read only when the word will have a buffer slot after this cycle's pop;
  // this bounds words pulled out of memory to BUF_DEPTH beyond those consumed.
  assign w_pop = w_buf_valid & rd_ready;
  assign w_occ = {1'b0, w_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_ren = !w_mem_empty && (w_occ < 3'(BUF_DEPTH));

  assign w_rbin_nxt  = r_rbin + {{(RPTRW-1){1'b0}}, 1'b1};
  assign w_rgray_nxt = RPTRW'(bin2gray({{(GRAYW-RPTRW){1'b0}}, w_rbin_nxt}));

  assign w_level = LVLW'(w_mem_count) + LVLW'(r_inflight) + LVLW'(w_buf_cnt);

  // Read pointer (binary and Gray kept in lockstep) and the in-flight flag.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_rbin     <= {RPTRW{1'b0}};
      r_rptr     <= {RPTRW{1'b0}};
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_ren;
      if (w_ren) begin
        r_rbin <= w_rbin_nxt;
        r_rptr <= w_rgray_nxt;
      end else begin
        r_rbin <= r_rbin;
        r_rptr <= r_rptr;
      end
    end
  end

  fifo_out_buf #(
    .DATAW(DATAW)
  ) u_out_buf (
    .clk        (rclk),
    .rst        (rrst),
    .i_push     (r_inflight),
    .i_push_data(rdata_mem),
    .i_pop      (w_pop),
    .o_data     (w_buf_data),
    .o_count    (w_buf_cnt),
    .o_valid    (w_buf_valid)
  );

  assign rptr     = r_rptr;
  assign raddr    = r_rbin[ADDRSIZE-1:0];
  assign ren      = w_ren;
  assign rd_data  = w_buf_data;
  assign rd_valid = w_buf_valid;
  assign rempty   = !w_buf_valid;
  assign rlevel   = w_level;
  assign raempty  = (w_level <= LVLW'(AEMPTY_TH));

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed testbench for fifo_read_ctrl (ADDRSIZE=3, DATAW=8, AEMPTY_TH=2).
// A small synchronous memory model answers reads one clock after ren.
module tb_fifo_read_ctrl;

  logic       rclk = 1'b0;
  logic       rrst;
  logic [3:0] sync_wptr;
  logic [3:0] rptr;
  logic [2:0] raddr;
  logic       ren;
  logic [7:0] rdata_mem = 8'h00;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic       rempty;
  logic       raempty;
  logic [4:0] rlevel;

  logic [7:0] tb_mem [8];
  int         checks = 0;
  int         errors = 0;
  logic       mon_en = 1'b0;
  logic [7:0] got_q [$];
  int         ren_seen = 0;

  fifo_read_ctrl #(.ADDRSIZE(3), .DATAW(8), .AEMPTY_TH(2)) dut (
    .rclk(rclk), .rrst(rrst), .sync_wptr(sync_wptr), .rptr(rptr),
    .raddr(raddr), .ren(ren), .rdata_mem(rdata_mem), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rempty(rempty),
    .raempty(raempty), .rlevel(rlevel)
  );

  always #5 rclk = ~rclk;

  // Synchronous memory read port.
  always @(posedge rclk) if (ren) rdata_mem <= tb_mem[raddr];

  // Record accepted words and issued reads.
  always @(negedge rclk) begin
    if (mon_en) begin
      if (rd_valid && rd_ready) got_q.push_back(rd_data);
      if (ren) ren_seen++;
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    rrst = 1'b1; sync_wptr = 4'b0000; rd_ready = 1'b0;
    tick(); tick();
    rrst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rrst = 1'b1; sync_wptr = 4'b0000; rd_ready = 1'b0;
    tick();
    checks++; if (rptr !== 4'b0000) begin errors++; $display("FAIL reset_rptr got %b exp 0000", rptr); end
    checks++; if (ren !== 1'b0) begin errors++; $display("FAIL reset_ren got %b exp 0", ren); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rd_valid); end
    checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL reset_rempty got %b exp 1", rempty); end
    checks++; if (raempty !== 1'b1) begin errors++; $display("FAIL reset_raempty got %b exp 1", raempty); end
    checks++; if (rlevel !== 5'd0) begin errors++; $display("FAIL reset_rlevel got %0d exp 0", rlevel); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", rd_data); end
    rrst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    tb_mem[0] = 8'hA5;
    sync_wptr = 4'b0001;
    #1;
    checks++; if (ren !== 1'b1) begin errors++; $display("FAIL single_ren got %b exp 1", ren); end
    checks++; if (raddr !== 3'd0) begin errors++; $display("FAIL single_raddr got %0d exp 0", raddr); end
    checks++; if (rlevel !== 5'd1) begin errors++; $display("FAIL single_rlevel got %0d exp 1", rlevel); end
    tick();
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", rd_valid); end
    checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", rd_data); end
    checks++; if (rptr !== 4'b0001) begin errors++; $display("FAIL single_rptr got %b exp 0001", rptr); end
    rd_ready = 1'b1;
    tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", rd_valid); end
    checks++; if (rlevel !== 5'd0) begin errors++; $display("FAIL single_level0 got %0d exp 0", rlevel); end
    rd_ready = 1'b0;
  endtask

  task automatic test_stream_full();
    do_reset();
    for (int i = 0; i < 8; i++) tb_mem[i] = 8'(i);
    rd_ready = 1'b1;
    sync_wptr = 4'b1100;
    for (int c = 0; c < 12; c++) begin
      #1;
      checks++; if (ren !== (c < 8)) begin errors++; $display("FAIL stream_ren c%0d got %b", c, ren); end
      checks++; if (rd_valid !== (c >= 1 && c <= 8)) begin errors++; $display("FAIL stream_valid c%0d got %b", c, rd_valid); end
      if (c >= 1 && c <= 8) begin
        checks++; if (rd_data !== 8'(c - 1)) begin errors++; $display("FAIL stream_data c%0d got %h exp %h", c, rd_data, 8'(c - 1)); end
      end
      tick();
    end
    checks++; if (rlevel !== 5'd0) begin errors++; $display("FAIL stream_rlevel got %0d exp 0", rlevel); end
    checks++; if (rptr !== 4'b1100) begin errors++; $display("FAIL stream_rptr got %b exp 1100", rptr); end
    checks++; if (raempty !== 1'b1) begin errors++; $display("FAIL stream_raempty got %b exp 1", raempty); end
    rd_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 5; i++) tb_mem[i] = 8'h50 + 8'(i);
    rd_ready = 1'b0;
    got_q.delete(); ren_seen = 0; mon_en = 1'b1;
    sync_wptr = 4'b0111;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c >= 1) begin
        checks++; if (rd_data !== 8'h50 || rd_valid !== 1'b1) begin errors++; $display("FAIL bp_hold c%0d got %h/%b exp 50/1", c, rd_data, rd_valid); end
      end
      tick();
    end
    checks++; if (ren_seen != 2) begin errors++; $display("FAIL bp_ren_count got %0d exp 2", ren_seen); end
    checks++; if (rlevel !== 5'd5) begin errors++; $display("FAIL bp_rlevel got %0d exp 5", rlevel); end
    checks++; if (raempty !== 1'b0) begin errors++; $display("FAIL bp_raempty got %b exp 0", raempty); end
    rd_ready = 1'b1;
    repeat (8) tick();
    mon_en = 1'b0;
    checks++; if (got_q.size() != 5) begin errors++; $display("FAIL bp_count got %0d exp 5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== 8'h50 + 8'(i)) begin errors++; $display("FAIL bp_word%0d got %h exp %h", i, got_q[i], 8'h50 + 8'(i)); end
    end
    checks++; if (rlevel !== 5'd0) begin errors++; $display("FAIL bp_level_end got %0d exp 0", rlevel); end
    rd_ready = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) tb_mem[i] = 8'h10 + 8'(i);
    rd_ready = 1'b1;
    got_q.delete(); mon_en = 1'b1;
    sync_wptr = 4'b1100;
    repeat (10) tick();
    for (int i = 0; i < 7; i++) tb_mem[i] = 8'h18 + 8'(i);
    sync_wptr = 4'b1000;
    repeat (10) tick();
    checks++; if (rptr !== 4'b1000) begin errors++; $display("FAIL wrap_rptr15 got %b exp 1000", rptr); end
    checks++; if (raddr !== 3'd7) begin errors++; $display("FAIL wrap_raddr7 got %0d exp 7", raddr); end
    tb_mem[7] = 8'h1F;
    tb_mem[0] = 8'h20;
    sync_wptr = 4'b0001;
    #1;
    checks++; if (ren !== 1'b1) begin errors++; $display("FAIL wrap_ren got %b exp 1", ren); end
    tick();
    checks++; if (rptr !== 4'b0000) begin errors++; $display("FAIL wrap_rptr0 got %b exp 0000", rptr); end
    checks++; if (raddr !== 3'd0) begin errors++; $display("FAIL wrap_raddr0 got %0d exp 0", raddr); end
    tick();
    checks++; if (rptr !== 4'b0001) begin errors++; $display("FAIL wrap_rptr1 got %b exp 0001", rptr); end
    checks++; if (raddr !== 3'd1) begin errors++; $display("FAIL wrap_raddr1 got %0d exp 1", raddr); end
    repeat (3) tick();
    mon_en = 1'b0;
    checks++; if (got_q.size() != 17) begin errors++; $display("FAIL wrap_count got %0d exp 17", got_q.size()); end
    for (int i = 0; i < 17 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== 8'h10 + 8'(i)) begin errors++; $display("FAIL wrap_word%0d got %h exp %h", i, got_q[i], 8'h10 + 8'(i)); end
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    tb_mem[0] = 8'hC3;
    rd_ready = 1'b0;
    sync_wptr = 4'b0001;
    #1;
    checks++; if (ren !== 1'b1) begin errors++; $display("FAIL mid_ren got %b exp 1", ren); end
    tick();
    rrst = 1'b1;
    sync_wptr = 4'b0000;
    #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", rd_valid); end
    checks++; if (rptr !== 4'b0000) begin errors++; $display("FAIL mid_rptr got %b exp 0000", rptr); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL mid_rdata got %h exp 00", rd_data); end
    checks++; if (rlevel !== 5'd0) begin errors++; $display("FAIL mid_rlevel got %0d exp 0", rlevel); end
    tick();
    rrst = 1'b0;
    rd_ready = 1'b1;
    got_q.delete(); mon_en = 1'b1;
    repeat (4) tick();
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mid_ghost got %0d words exp 0", got_q.size()); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL mid_rdata_idle got %h exp 00", rd_data); end
    tb_mem[0] = 8'h77;
    sync_wptr = 4'b0001;
    #1;
    checks++; if (ren !== 1'b1 || raddr !== 3'd0) begin errors++; $display("FAIL mid_restart got ren %b raddr %0d exp 1/0", ren, raddr); end
    tick();
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h77) begin errors++; $display("FAIL mid_newword got %b/%h exp 1/77", rd_valid, rd_data); end
    tick();
    mon_en = 1'b0;
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h77) begin errors++; $display("FAIL mid_delivered got %0d words exp 1 word 77", got_q.size()); end
    rd_ready = 1'b0;
  endtask

  initial begin
    rrst = 1'b1; sync_wptr = 4'b0000; rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) tb_mem[i] = 8'h00;
    test_reset();
    test_single();
    test_stream_full();
    test_backpressure();
    test_wrap();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
